// File: rtl/wbscope_pro.sv
// Wishbone-controlled capture scope: circular sample buffer, selectable trigger
// source, post-trigger holdoff, and a register interface for control and readout.
module wbscope_pro #(
  parameter int unsigned LGMEM       = 10,
  parameter int unsigned DW          = 32,
  parameter int unsigned DEF_HOLDOFF = 1,
  parameter logic [1:0]  DEF_MODE    = 2'b00
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ce,
  input  logic          i_trigger,
  input  logic [DW-1:0] i_data,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [1:0]    i_wb_addr,
  input  logic [31:0]   i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [31:0]   o_wb_data,
  output logic          o_interrupt
);
  // state     | meaning
  // PRIMING   | filling the buffer after reset/rearm; triggers ignored
  // ARMED     | buffer holds a full history; waiting for a trigger
  // TRIGGERED | trigger seen; counting down post-trigger samples
  // STOPPED   | capture frozen; buffer readable through address 1
  typedef enum logic [1:0] {PRIMING, ARMED, TRIGGERED, STOPPED} state_e;

  localparam int unsigned NMEM = 1 << LGMEM;
  localparam logic [19:0] HMAX = 20'(NMEM - 1);

  state_e            state_q, state_d;
  logic [DW-1:0]     mem_q [NMEM];
  logic [LGMEM-1:0]  wr_ptr_q, rd_ptr_q, cnt_q;
  logic [19:0]       holdoff_q, hcnt_q;
  logic [1:0]        mode_q;
  logic [DW-1:0]     mask_q, value_q;
  logic              prev_trig_q, man_q, ack_q;
  logic [31:0]       rdata_q, rdata_d, status;

  logic wb_req, ctl_wr, rearm, wr_en, trig_cond, trig_evt, enter_stop, rd_adv;
  logic unused_ok;

  assign wb_req  = i_wb_stb && i_wb_cyc;
  assign ctl_wr  = wb_req && i_wb_we && (i_wb_addr == 2'd0);
  assign rearm   = ctl_wr && i_wb_data[30];
  assign wr_en   = i_ce && (state_q != STOPPED);
  assign rd_adv  = wb_req && !i_wb_we && (i_wb_addr == 2'd1) && (state_q == STOPPED);
  assign unused_ok = ^i_wb_data;

  always_comb begin
    trig_cond = 1'b0;
    case (mode_q)
      2'b00:   trig_cond = i_trigger;
      2'b01:   trig_cond = i_trigger && !prev_trig_q;
      2'b10:   trig_cond = ((i_data ^ value_q) & mask_q) == '0;
      default: trig_cond = 1'b0;
    endcase
  end

  // A pending manual trigger waits for the first ARMED sample.
  assign trig_evt = (state_q == ARMED) && i_ce && (trig_cond || man_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= PRIMING;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rearm) begin
      state_d = PRIMING;
    end else begin
      case (state_q)
        PRIMING:   if (wr_en && (cnt_q == '1)) state_d = ARMED;
        ARMED:     if (trig_evt) state_d = (holdoff_q == '0) ? STOPPED : TRIGGERED;
        TRIGGERED: if (wr_en && (hcnt_q <= 20'd1)) state_d = STOPPED;
        default:   state_d = STOPPED;
      endcase
    end
  end

  always_comb begin
    o_interrupt = (state_q == STOPPED);
    o_wb_stall  = 1'b0;
    o_wb_ack    = ack_q;
    o_wb_data   = rdata_q;
  end

  assign enter_stop = (state_d == STOPPED) && (state_q != STOPPED);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      prev_trig_q <= 1'b0;
      man_q       <= 1'b0;
    end else if (rearm) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      prev_trig_q <= 1'b0;
      man_q       <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + LGMEM'(1);
        if (state_q == PRIMING) cnt_q <= cnt_q + LGMEM'(1);
      end
      if (i_ce) prev_trig_q <= i_trigger;
      if (trig_evt)                          hcnt_q <= holdoff_q;
      else if (state_q == TRIGGERED && wr_en) hcnt_q <= hcnt_q - 20'd1;
      if (trig_evt)
        man_q <= 1'b0;
      else if (ctl_wr && i_wb_data[31] && (state_q == PRIMING || state_q == ARMED))
        man_q <= 1'b1;
      // Stopping always coincides with a write, so the oldest sample sits one past it.
      if (enter_stop)  rd_ptr_q <= wr_ptr_q + LGMEM'(1);
      else if (rd_adv) rd_ptr_q <= rd_ptr_q + LGMEM'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      holdoff_q <= 20'(DEF_HOLDOFF);
      mode_q    <= DEF_MODE;
      mask_q    <= '0;
      value_q   <= '0;
    end else if (wb_req && i_wb_we) begin
      case (i_wb_addr)
        2'd0: begin
          holdoff_q <= (i_wb_data[19:0] > HMAX) ? HMAX : i_wb_data[19:0];
          mode_q    <= i_wb_data[21:20];
        end
        2'd2:    mask_q  <= i_wb_data[DW-1:0];
        2'd3:    value_q <= i_wb_data[DW-1:0];
        default: ;
      endcase
    end
  end

  assign status = {state_q == STOPPED,
                   (state_q == TRIGGERED) || (state_q == STOPPED),
                   state_q != PRIMING,
                   1'b0, 4'(LGMEM), 2'b00, mode_q, holdoff_q};

  always_comb begin
    rdata_d = '0;
    case (i_wb_addr)
      2'd0:    rdata_d = status;
      2'd1:    if (state_q == STOPPED) rdata_d = 32'(mem_q[rd_ptr_q]);
      2'd2:    rdata_d = 32'(mask_q);
      default: rdata_d = 32'(value_q);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= wb_req;
      if (wb_req) rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_wbscope_pro.sv
// Testbench for wbscope_pro (LGMEM=6, DW=32): counter sample stream, Wishbone
// reads checked against a queue of expected values.
module tb_wbscope_pro;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_ce = 1'b1, i_trigger = 1'b0;
  logic [31:0] i_data, data_cnt;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [1:0]  i_wb_addr = 2'd0;
  logic [31:0] i_wb_data = 32'd0;
  logic        o_wb_ack, o_wb_stall, o_interrupt;
  logic [31:0] o_wb_data;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_wr_cnt, rd_val;

  wbscope_pro #(.LGMEM(6), .DW(32), .DEF_HOLDOFF(1), .DEF_MODE(2'b00)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_trigger(i_trigger),
    .i_data(i_data), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(o_wb_ack),
    .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data), .o_interrupt(o_interrupt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) data_cnt <= 32'd0;
    else          data_cnt <= data_cnt + 32'd1;
  assign i_data = data_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_trigger = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic wb_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge i_clk);
    last_wr_cnt = data_cnt;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_addr = addr; i_wb_data = data;
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    chk("wr_ack", {31'd0, o_wb_ack}, 32'd1);
  endtask

  // Back-to-back read strobes; each ack pops one expected value.
  task automatic wb_burst(input logic [1:0] addr, input int n, input string tag);
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = addr;
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      if (k == n - 1) begin i_wb_cyc = 1'b0; i_wb_stb = 1'b0; end
      chk({tag, "_ack"}, {31'd0, o_wb_ack}, 32'd1);
      if (exp_q.size() > 0) chk(tag, o_wb_data, exp_q.pop_front());
      else                  chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic wb_read1(input logic [1:0] addr, output logic [31:0] data);
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = addr;
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    chk("rd1_ack", {31'd0, o_wb_ack}, 32'd1);
    data = o_wb_data;
  endtask

  task automatic wait_cnt(input logic [31:0] v);
    int k = 0;
    while (data_cnt != v && k < 2000) begin @(negedge i_clk); k++; end
    if (k >= 2000) chk("wait_cnt_timeout", data_cnt, v);
  endtask

  task automatic pulse_at(input logic [31:0] v);
    wait_cnt(v);
    i_trigger = 1'b1;
    @(negedge i_clk);
    i_trigger = 1'b0;
  endtask

  task automatic wait_irq(input int max, input string tag);
    int k = 0;
    while (!o_interrupt && k < max) begin @(negedge i_clk); k++; end
    chk(tag, {31'd0, o_interrupt}, 32'd1);
  endtask

  task automatic push_range(input int first, input int last);
    for (int v = first; v <= last; v++) exp_q.push_back(32'(v));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, checked while reset is held.
    i_rst_n = 1'b0;
    #12;
    chk("rst_irq", {31'd0, o_interrupt}, 32'd0);
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_data", o_wb_data, 32'd0);
    chk("rst_stall", {31'd0, o_wb_stall}, 32'd0);
    do_reset();
    exp_q.push_back(32'h0600_0001); wb_burst(2'd0, 1, "rst_status");
    exp_q.push_back(32'd0);         wb_burst(2'd1, 1, "buf_not_stopped");

    // Mode 00, holdoff 1, trigger at 100.
    do_reset();
    pulse_at(100);
    chk("irq_early", {31'd0, o_interrupt}, 32'd0);
    @(negedge i_clk);
    chk("irq_stop", {31'd0, o_interrupt}, 32'd1);
    exp_q.push_back(32'hE600_0001); wb_burst(2'd0, 1, "stop_status");
    push_range(38, 101); exp_q.push_back(32'd38);
    wb_burst(2'd1, 65, "buf100");

    // Trigger during PRIMING is ignored; later one at 200 is taken.
    do_reset();
    pulse_at(10);
    wait_cnt(50);
    exp_q.push_back(32'h0600_0001); wb_burst(2'd0, 1, "prime_status");
    wait_cnt(80);
    exp_q.push_back(32'h2600_0001); wb_burst(2'd0, 1, "armed_status");
    pulse_at(200);
    wait_irq(5, "irq200");
    push_range(138, 201); wb_burst(2'd1, 64, "buf200");

    // Mode 11: external trigger ignored, manual trigger with holdoff 2.
    do_reset();
    wb_write(2'd0, 32'h0030_0002);
    pulse_at(125);
    repeat (10) @(negedge i_clk);
    chk("mode3_no_stop", {31'd0, o_interrupt}, 32'd0);
    wb_write(2'd0, 32'h8030_0002);
    wait_irq(10, "irq_manual");
    push_range(int'(last_wr_cnt) - 60, int'(last_wr_cnt) + 3);
    wb_burst(2'd1, 64, "buf_manual");

    // Mode 10 pattern match, holdoff 0.
    do_reset();
    wb_write(2'd2, 32'h0000_00FF);
    wb_write(2'd3, 32'h0000_0080);
    exp_q.push_back(32'h0000_00FF); wb_burst(2'd2, 1, "mask_rd");
    exp_q.push_back(32'h0000_0080); wb_burst(2'd3, 1, "value_rd");
    wb_write(2'd0, 32'h4020_0000);
    wait_irq(300, "irq_match");
    wb_read1(2'd0, rd_val);
    chk("match_status", rd_val & ~32'h4000_0000, 32'hA620_0000);
    push_range(65, 128); wb_burst(2'd1, 64, "buf_match");

    // Rearm during TRIGGERED with oversized holdoff.
    do_reset();
    wb_write(2'd0, 32'h0000_0014);
    pulse_at(100);
    exp_q.push_back(32'h6600_0014); wb_burst(2'd0, 1, "trig_status");
    i_trigger = 1'b1;
    wb_write(2'd0, 32'h4000_03E8);
    i_trigger = 1'b0;
    chk("rearm_irq", {31'd0, o_interrupt}, 32'd0);
    exp_q.push_back(32'h0600_003F); wb_burst(2'd0, 1, "rearm_status");
    repeat (30) @(negedge i_clk);
    chk("rearm_no_stop", {31'd0, o_interrupt}, 32'd0);

    // Mode 01 rising edge, trigger held high from rearm.
    do_reset();
    i_trigger = 1'b1;
    wb_write(2'd0, 32'h4010_0001);
    wait_cnt(140);
    chk("edge_held_no_stop", {31'd0, o_interrupt}, 32'd0);
    wait_cnt(148); i_trigger = 1'b0;
    wait_cnt(150); i_trigger = 1'b1;
    wait_irq(5, "irq_edge");
    i_trigger = 1'b0;
    push_range(88, 151); wb_burst(2'd1, 64, "buf_edge");

    // Asynchronous reset while STOPPED with an ack outstanding.
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 2'd0;
    @(posedge i_clk); #1;
    chk("pre_rst_ack", {31'd0, o_wb_ack}, 32'd1);
    chk("pre_rst_irq", {31'd0, o_interrupt}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_irq", {31'd0, o_interrupt}, 32'd0);
    chk("async_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("async_data", o_wb_data, 32'd0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_q.push_back(32'h0600_0001); wb_burst(2'd0, 1, "post_rst_status");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
